// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit
//   Clocked N-operand, WIDTH-bit gate. Operands arrive as a framed stream over
//   a valid/ready handshake and are folded bitwise (AND/OR/XOR, optionally
//   inverted at the result). One registered result per frame is presented on
//   a second valid/ready port together with the beat count, a truncation flag
//   (frame closed by MAX_BEATS rather than in_last) and a reserved-mode flag.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   mode[2:0]            gate select, sampled on the first beat of a frame
//   in_valid/in_ready    operand handshake; in_data operand, in_last frame end
//   out_valid/out_ready  result handshake
//   out_data             reduced result
//   out_count            beats folded into out_data
//   out_trunc            frame closed by MAX_BEATS
//   out_err              reserved mode code used for this frame
module logic_reduce_unit #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_trunc,
  output logic             out_err
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR} op_e;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             inv_q, inv_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic             out_trunc_q, out_trunc_d;
  logic             out_err_q, out_err_d;

  function automatic logic [WIDTH-1:0] apply_op(op_e op, logic [WIDTH-1:0] a,
                                                logic [WIDTH-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return a | b;
    endcase
  endfunction

  // Held low during reset even though the state register already reads IDLE.
  assign in_ready = rst_n & (state_q != DONE);

  logic             beat_ok;
  op_e              mode_op;
  logic             mode_inv;
  logic             mode_err;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             hit_max;

  always_comb begin
    beat_ok  = in_valid & in_ready;

    case (mode)
      3'b000, 3'b011: mode_op = OP_AND;
      3'b010, 3'b101: mode_op = OP_XOR;
      default:        mode_op = OP_OR;
    endcase
    mode_inv = (mode == 3'b011) || (mode == 3'b100) || (mode == 3'b101);
    mode_err = mode[2] & mode[1];

    acc_nxt  = apply_op(op_q, acc_q, in_data);
    cnt_nxt  = cnt_q + CNT_ONE;
    hit_max  = (cnt_nxt == CNT_MAX);

    state_d     = state_q;
    op_d        = op_q;
    inv_d       = inv_q;
    err_d       = err_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_trunc_d = out_trunc_q;
    out_err_d   = out_err_q;

    case (state_q)
      IDLE: begin
        if (beat_ok) begin
          op_d  = mode_op;
          inv_d = mode_inv;
          err_d = mode_err;
          acc_d = in_data;
          cnt_d = CNT_ONE;
          if (in_last) begin
            // Single-beat frame closes straight from IDLE, so the result is
            // built from the freshly decoded mode rather than the flops.
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = mode_inv ? ~in_data : in_data;
            out_count_d = CNT_ONE;
            out_trunc_d = 1'b0;
            out_err_d   = mode_err;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (beat_ok) begin
          acc_d = acc_nxt;
          cnt_d = cnt_nxt;
          if (in_last || hit_max) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = inv_q ? ~acc_nxt : acc_nxt;
            out_count_d = cnt_nxt;
            out_trunc_d = hit_max & ~in_last;
            out_err_d   = err_q;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_AND;
      inv_q       <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_trunc_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      inv_q       <= inv_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_trunc_q <= out_trunc_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_trunc = out_trunc_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_logic_reduce_unit.sv
// tb_logic_reduce_unit
//   Directed plus small randomized bench for logic_reduce_unit (WIDTH=8,
//   MAX_BEATS=4). Expected results are queued when a frame is driven and
//   compared when the unit presents its result.
module tb_logic_reduce_unit;

  localparam int W  = 8;
  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);

  logic          clk;
  logic          rst_n;
  logic [2:0]    mode;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_trunc;
  logic          out_err;

  logic_reduce_unit #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_trunc (out_trunc),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [CW-1:0] c;
    logic          t;
    logic          e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until the unit accepts it.
  task automatic send(input logic [2:0] m, input logic [W-1:0] d, input logic last);
    int unsigned guard;
    guard    = 0;
    mode     = m;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("send_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag);
    int unsigned guard;
    exp_t e;
    guard = 0;
    while (!out_valid && guard < 50) begin
      tick();
      guard++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sb"}, sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_data"},  {24'd0, out_data},  {24'd0, e.d});
      chk({tag, "_count"}, {29'd0, out_count}, {29'd0, e.c});
      chk({tag, "_trunc"}, {31'd0, out_trunc}, {31'd0, e.t});
      chk({tag, "_err"},   {31'd0, out_err},   {31'd0, e.e});
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    chk({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  function automatic exp_t model(input logic [2:0] m, input logic [W-1:0] b [MB],
                                 input int n, input logic closed_by_last);
    exp_t r;
    logic [W-1:0] acc;
    acc = b[0];
    for (int i = 1; i < n; i++) begin
      if (m == 3'b000 || m == 3'b011)      acc = acc & b[i];
      else if (m == 3'b010 || m == 3'b101) acc = acc ^ b[i];
      else                                 acc = acc | b[i];
    end
    if (m == 3'b011 || m == 3'b100 || m == 3'b101) acc = ~acc;
    r.d = acc;
    r.c = CW'(n);
    r.t = ~closed_by_last;
    r.e = (m >= 3'b110);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] beats [MB];
    logic [2:0]   rm;
    int           rn;
    logic         rlast;

    rst_n     = 1'b1;
    mode      = 3'b000;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Asynchronous reset asserted between clock edges.
    #12 rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_out_count", {29'd0, out_count}, 32'd0);
    chk("rst_out_trunc", {31'd0, out_trunc}, 32'd0);
    chk("rst_out_err",   {31'd0, out_err},   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // OR, 2 beats, single-cycle result.
    sb.push_back('{d: 8'hFF, c: CW'(2), t: 1'b0, e: 1'b0});
    send(3'b001, 8'h0F, 1'b0);
    send(3'b001, 8'hF0, 1'b1);
    expect_result("or2");
    handshake("or2");

    // NAND over 3 beats.
    sb.push_back('{d: 8'hCC, c: CW'(3), t: 1'b0, e: 1'b0});
    send(3'b011, 8'hFF, 1'b0);
    send(3'b011, 8'hF3, 1'b0);
    send(3'b011, 8'h3F, 1'b1);
    expect_result("nand3");
    handshake("nand3");

    // XNOR over 3 beats.
    sb.push_back('{d: 8'hF8, c: CW'(3), t: 1'b0, e: 1'b0});
    send(3'b101, 8'h01, 1'b0);
    send(3'b101, 8'h02, 1'b0);
    send(3'b101, 8'h04, 1'b1);
    expect_result("xnor3");
    handshake("xnor3");

    // XOR frame closed by MAX_BEATS, then a single-beat frame.
    sb.push_back('{d: 8'h0F, c: CW'(4), t: 1'b1, e: 1'b0});
    send(3'b010, 8'h01, 1'b0);
    send(3'b010, 8'h02, 1'b0);
    send(3'b010, 8'h04, 1'b0);
    send(3'b010, 8'h08, 1'b0);
    expect_result("trunc");
    handshake("trunc");
    sb.push_back('{d: 8'hAA, c: CW'(1), t: 1'b0, e: 1'b0});
    send(3'b010, 8'hAA, 1'b1);
    expect_result("single");
    handshake("single");

    // Mode latched on first beat; backpressure stall with beats offered.
    out_ready = 1'b0;
    sb.push_back('{d: 8'h30, c: CW'(2), t: 1'b0, e: 1'b0});
    send(3'b000, 8'hF0, 1'b0);
    send(3'b001, 8'h3C, 1'b1);
    expect_result("latch");
    mode     = 3'b001;
    in_data  = 8'h55;
    in_last  = 1'b1;
    in_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data",  {24'd0, out_data},  32'h30);
      chk("stall_ready", {31'd0, in_ready},  32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    handshake("latch");

    // Reserved mode, single beat.
    sb.push_back('{d: 8'h5A, c: CW'(1), t: 1'b0, e: 1'b1});
    send(3'b111, 8'h5A, 1'b1);
    expect_result("resv");
    handshake("resv");

    // Reset in the middle of a frame discards it.
    send(3'b001, 8'h11, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready},  32'd0);
    chk("mid_rst_valid",    {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data",     {24'd0, out_data},  32'd0);
    chk("mid_rst_err",      {31'd0, out_err},   32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    sb.push_back('{d: 8'h26, c: CW'(2), t: 1'b0, e: 1'b0});
    send(3'b000, 8'h66, 1'b0);
    send(3'b000, 8'h2F, 1'b1);
    expect_result("fresh");
    handshake("fresh");

    // Randomized frames; later beats carry a different mode to exercise the latch.
    for (int f = 0; f < 8; f++) begin
      rm = 3'($urandom_range(0, 7));
      rn = int'($urandom_range(1, MB));
      rlast = !(rn == MB && $urandom_range(0, 1) == 1);
      for (int i = 0; i < MB; i++) beats[i] = W'($urandom);
      sb.push_back(model(rm, beats, rn, rlast));
      for (int i = 0; i < rn; i++)
        send((i == 0) ? rm : 3'($urandom_range(0, 7)), beats[i], (i == rn - 1) && rlast);
      expect_result("rand");
      handshake("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/logic_reduce_unit.md
# logic_reduce_unit

- Parametrised, clocked successor to the two-input gate blocks.
- Accepts a framed stream of WIDTH-bit operands over a valid/ready handshake.
- Reduces the frame bitwise with a selectable gate function (AND/OR/XOR and inverted forms).
- Presents one registered result per frame, with beat count and truncation flag, on a second valid/ready port.
- Sits in the gate library as the general-purpose N-operand, W-bit gate; the two-input combinational gates become the special case of a 2-beat frame.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- MAX_BEATS, 16, maximum beats per frame (≥2); CW = $clog2(MAX_BEATS+1)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- mode  in  3  gate select, sampled on first beat of frame: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110/111 reserved
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat
- in_data  in  WIDTH  operand
- in_last  in  1  final beat of frame
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  reduced result
- out_count  out  CW  beats reduced into out_data (1..MAX_BEATS)
- out_trunc  out  1  frame closed by MAX_BEATS, not by in_last
- out_err  out  1  reserved mode code was used for this frame

## Operation
- States:
  - IDLE: in_ready=1; no frame open.
  - ACC: in_ready=1; frame open.
  - DONE: in_ready=0, out_valid=1.
- Beat accepted = in_valid & in_ready at a rising edge.
- IDLE on accept:
  - acc←in_data, cnt←1.
  - Latch mode: base op = AND for 000/011, OR for 001/100/110/111, XOR for 010/101. inv=1 for 011/100/101. err=1 for 110/111.
  - If in_last → DONE, else → ACC.
- ACC on accept:
  - acc←acc op in_data, cnt←cnt+1.
  - If in_last or cnt+1==MAX_BEATS → DONE.
  - trunc=1 only when MAX_BEATS is reached with in_last=0.
- Entering DONE registers:
  - out_data = inv ? ~acc_final : acc_final.
  - out_count = final cnt.
  - out_trunc, out_err as computed for the frame.
- DONE: hold all out_* stable until out_valid & out_ready. Then → IDLE; out_valid←0. out_data/out_count/out_trunc/out_err keep their last values.
- Inversion is applied once, at the result, never per beat. NAND over N beats = ~(AND of all beats).
- mode changes after the first beat are ignored until the next frame.
- in_data/in_last are ignored when no beat is accepted.
- Single-beat frame: out_data = in_data (or ~in_data if inv), out_count=1.
- After a truncated frame, the next accepted beat starts a new frame. The upstream remainder is treated as a new frame; no beats are dropped.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - out_valid=0, out_data=0, out_count=0, out_trunc=0, out_err=0.
  - in_ready forced 0 while rst_n=0.
  - Internal acc/cnt/mode cleared.
- Reset mid-frame or mid-DONE discards the frame; no partial result is emitted.
- in_ready is combinational from state only: 1 in IDLE/ACC, 0 in DONE. It never depends on in_valid.
- Latency: out_valid rises on the edge that accepts the closing beat, so it is visible the following cycle.
- Throughput: an N-beat frame takes N cycles, plus ≥1 cycle in DONE. Frames are not overlapped; the next frame's first beat is accepted no earlier than the cycle after the result handshake.
- out_ready held 0: unit stalls indefinitely in DONE with outputs stable; in_ready=0.
- out_ready=1 on entry to DONE: result handshakes in the first DONE cycle; IDLE on the next edge.
- All outputs except in_ready are registered.

## Test plan
Run with WIDTH=8, MAX_BEATS=4.
- Reset: rst_n=0 asynchronously mid-cycle → all out_* = 0 and in_ready=0 immediately. After release → in_ready=1, state IDLE.
- OR, 2 beats: mode=001, beats 0x0F then 0xF0 (last), out_ready=1 → out_data=0xFF, out_count=2, out_trunc=0, out_err=0. out_valid is high for exactly 1 cycle.
- NAND/XNOR, 3 beats:
  - mode=011, beats 0xFF, 0xF3, 0x3F (last) → out_data=0xCC (~0x33), count=3.
  - Repeat with mode=101, beats 0x01, 0x02, 0x04 → out_data=0xF8.
- Truncation: mode=010, beats 0x01, 0x02, 0x04, 0x08 with in_last=0 throughout → out_data=0x0F, count=4, out_trunc=1. A following single beat 0xAA with in_last=1 → out_data=0xAA, count=1, trunc=0.
- Backpressure and mode latch:
  - mode=000, beats 0xF0, 0x3C (last); mode flipped to 001 after the first beat → out_data=0x30.
  - Hold out_ready=0 for 5 cycles → out_valid stays 1, out_data stable, in_ready=0, offered beats not accepted.
- Reserved mode and single beat: mode=111, single beat 0x5A with last → out_data=0x5A, out_err=1. Assert rst_n=0 during a later 2-beat frame after beat 1 → no out_valid; the next frame reduces from fresh state.
